// File: rtl/gf_op_scheduler.sv
// Round-robin scheduler sharing one GF(2^m) operand bank and arithmetic unit among NREQ requesters.
// Define GF_SCHED_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT cycles.

module gf_op_scheduler #(
    parameter int unsigned DATA    = 256,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [9:0]               Polynomial_Length,
    input  logic [NREQ-1:0]          req,
    input  logic [3*NREQ-1:0]        req_op,
    input  logic [NREQ-1:0]          wr_valid,
    input  logic [2*DATA*NREQ-1:0]   wr_data,
    output logic [NREQ-1:0]          wr_ready,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     op_err,
    output logic                     busy,
    output logic [2:0]               command,
    output logic [2*DATA-1:0]        Data_in,
    output logic                     fifo_dump,
    input  logic                     unit_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW = 2 * DATA;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StLoad,
        StGap,
        StDump,
        StWait,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [2:0]      op_q, op_d;
    logic [1:0]      n_q, n_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [DW-1:0]   data_q, data_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic [2:0]      win_op;
    logic            op_ok;
    logic            len_ok;
    logic [1:0]      len_n;
    logic [DW-1:0]   own_word;
    logic            own_valid;

`ifdef GF_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tmo_q, tmo_d;
`else
    logic            unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // First set request at or after the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = PW'((int'(ptr_q) + i) % int'(NREQ));
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_op    = '0;
        own_word  = '0;
        own_valid = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_idx == PW'(i)) begin
                win_op = req_op[3*i +: 3];
            end
            if (owner_q == PW'(i)) begin
                own_word  = wr_data[DW*i +: DW];
                own_valid = wr_valid[i];
            end
        end
    end

    always_comb begin
        len_n  = 2'd0;
        len_ok = 1'b1;
        if (Polynomial_Length == 10'd0 || Polynomial_Length > 10'd768) begin
            len_ok = 1'b0;
        end else if (Polynomial_Length <= 10'd256) begin
            len_n = 2'd1;
        end else if (Polynomial_Length <= 10'd512) begin
            len_n = 2'd2;
        end else begin
            len_n = 2'd3;
        end
    end

    assign op_ok = (win_op >= 3'd1) && (win_op <= 3'd4);
    assign busy  = (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        op_d      = op_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        data_d    = data_q;
        gnt       = '0;
        wr_ready  = '0;
        done      = '0;
        op_err    = 1'b0;
        command   = 3'd0;
        Data_in   = data_q;
        fifo_dump = 1'b0;
`ifdef GF_SCHED_TIMEOUT_EN
        tmo_d     = '0;
`endif
        if (state_q != StIdle && state_q != StArb) begin
            gnt[owner_q] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (!win_found) begin
                    state_d = StIdle;
                end else begin
                    gnt[win_idx] = 1'b1;
                    owner_d      = win_idx;
                    op_d         = win_op;
                    n_d          = len_n;
                    cnt_d        = 2'd0;
                    err_d        = !(op_ok && len_ok);
                    ptr_d        = (int'(win_idx) == int'(NREQ) - 1) ? '0 : win_idx + PW'(1);
                    state_d      = (op_ok && len_ok) ? StLoad : StDone;
                end
            end
            StLoad: begin
                wr_ready[owner_q] = 1'b1;
                if (own_valid) begin
                    command = op_q;
                    Data_in = own_word;
                    data_d  = own_word;
                    if (cnt_q == n_q - 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (cnt_q != 2'd0) begin
                    // A gap after the first word would rewind the bank mid-operand.
                    cnt_d   = 2'd0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StGap: begin
                state_d = StDump;
            end
            StDump: begin
                fifo_dump = 1'b1;
                command   = op_q;
                if (cnt_q == n_q - 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StWait: begin
                if (unit_done) begin
                    state_d = StDone;
                end
`ifdef GF_SCHED_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            StDone: begin
                done[owner_q] = 1'b1;
                op_err        = err_q;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            op_q    <= 3'd0;
            n_q     <= 2'd0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

`ifdef GF_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

endmodule

// File: doc/gf_op_scheduler.md
Name: gf_op_scheduler

Overview:
- Round-robin scheduler sharing one GF(2^m) operand register bank and arithmetic unit between NREQ requesters.
- Grants one requester, then streams its 1–3 operand words into the bank with the matching command code.
- Inserts the command-0 gap the bank needs to rewind its load counter, then replays the words with fifo_dump.
- Waits for the unit's completion and returns a done pulse to the owner.

Parameters:
- DATA, 256, operand word width in bits.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, WAIT-state watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- Polynomial_Length  in  10  field degree m; sampled at grant.
- req  in  NREQ  per-requester operation request; level, held until done.
- req_op  in  3*NREQ  per-requester opcode: 1 Mul, 2 Sqr, 3 Inv, 4 Xor.
- wr_valid  in  NREQ  operand word valid.
- wr_data  in  2*DATA*NREQ  operand word; B in the upper DATA bits, A in the lower.
- wr_ready  out  NREQ  operand word accepted; asserted only to the owner.
- gnt  out  NREQ  one-hot owner; held from ARB through DONE.
- done  out  NREQ  one-cycle completion pulse to the owner.
- op_err  out  1  qualifies done: illegal op or illegal length.
- busy  out  1  high in every state except IDLE.
- command  out  3  command to the register bank.
- Data_in  out  2*DATA  operand word to the register bank.
- fifo_dump  out  1  replay enable to the register bank.
- unit_done  in  1  arithmetic unit finished; single-cycle pulse.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; round-robin pointer 0; word counter 0.
- Word count N, latched at grant from Polynomial_Length L:
  - 1 if 1≤L≤256.
  - 2 if 257≤L≤512.
  - 3 if 513≤L≤768.
  - L=0 or L>768 is illegal.
- Opcodes other than 1–4 are illegal.
- IDLE: command=0. If any req is set, go to ARB.
- ARB (1 cycle):
  - Pick the first set req at or after the pointer, with wrap-around; assert gnt.
  - Latch op, N and the legal flag; set pointer = winner+1 mod NREQ.
  - Illegal op/length → DONE with op_err=1.
  - Otherwise → LOAD.
- LOAD:
  - wr_ready[owner]=1.
  - Each cycle with wr_valid[owner]: command=op, Data_in=word, counter++.
  - A cycle without wr_valid: command=0 and Data_in held. This stall also rewinds the bank; the bench therefore requires wr_valid back-to-back for the N words, and a stall mid-LOAD aborts to DONE with op_err=1.
  - After N accepted words → GAP.
- GAP (1 cycle): command=0, which resets the bank's load counter. → DUMP.
- DUMP:
  - fifo_dump=1 for exactly N cycles while command is held at op.
  - Then fifo_dump=0, command=0 → WAIT.
- WAIT: command=0. On unit_done → DONE.
- DONE (1 cycle): done[owner]=1, op_err as latched; gnt drops next cycle. → IDLE.
- A requester must deassert req within one cycle of done, otherwise it re-enters arbitration on its next turn.
- unit_done outside WAIT is ignored.
- Latency, legal op, no stalls: ARB 1 + LOAD N + GAP 1 + DUMP N + WAIT k + DONE 1 cycles.
- Polynomial_Length and req_op changes after ARB are ignored.
- rst_n low mid-operation aborts immediately to reset values; no done is issued.

Optional Feature:
- Macro GF_SCHED_TIMEOUT_EN.
- When defined: a WAIT cycle counter is present. If unit_done is not seen within TIMEOUT cycles, go to DONE with op_err=1.
- When undefined: WAIT waits indefinitely; the counter logic is absent.

Test Plan:
- req[0], op=1, L=163, one word A=0x5,B=0x3 → command=1 for 1 cycle, GAP command=0, fifo_dump 1 cycle; unit_done 4 cycles later → done[0] at cycle 8, op_err=0.
- req[1], op=4, L=571, three back-to-back words → three LOAD cycles, fifo_dump high exactly 3 cycles, done[1] after unit_done.
- req=4'b1111 held, each requester drops req after its done → grants in order 0,1,2,3; a repeat request from 0 is then granted before 1.
- op=6 or L=800 → ARB then DONE, op_err=1; no command or fifo_dump activity.
- Reset asserted during DUMP → outputs 0 immediately; after release a new req[2] completes normally.
- With GF_SCHED_TIMEOUT_EN, TIMEOUT=16, no unit_done → done with op_err=1 exactly 16 cycles after entering WAIT.
